// File: rtl/cache_request_servicer_pkg.sv
// ---------------------------------------------------------------------------
// cache_request_servicer_pkg
//
// Purpose : shared definitions for the cache request servicer: command
//           encodings, the bit positions inside a command, the FSM state
//           type and the CLOG2 helper macro.
// Ports   : none (package).
// ---------------------------------------------------------------------------
`define CLOG2(x) $clog2(x)

package cache_request_servicer_pkg;

    // Command encodings as they arrive from the request buffer.
    localparam logic [2:0] CMD_WORD_RD = 3'b000;
    localparam logic [2:0] CMD_WORD_WR = 3'b001;
    localparam logic [2:0] CMD_BLK_RD  = 3'b010;
    localparam logic [2:0] CMD_BLK_WR  = 3'b011;

    // Bit positions inside a command word.
    localparam int CMD_WRITE_BIT   = 0;
    localparam int CMD_BLOCK_BIT   = 1;
    localparam int CMD_NOCACHE_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/cache_request_servicer.sv
// ---------------------------------------------------------------------------
// cache_request_servicer
//
// Purpose : memory-side consumer of the cache request buffer. Pops one
//           command/address/data entry at a time, executes it on the
//           single-word memory port as a word or block read/write, and
//           returns read results to the cache on a valid/ready channel.
//           One request in flight, strictly in order.
//
// Ports   :
//   clock_i, resetn_i              clock, asynchronous active-low reset
//   empty_i, command_i, addr_i,
//   data_i, read_o                 request buffer head and pop strobe
//   mem_req_o, mem_wren_o,
//   mem_addr_o, mem_data_o,
//   mem_ack_i, mem_data_i          single-word memory port
//   resp_valid_o, resp_ready_i,
//   resp_command_o, resp_addr_o,
//   resp_data_o                    read response channel
//   busy_o                         FSM not idle
// ---------------------------------------------------------------------------
module cache_request_servicer
    import cache_request_servicer_pkg::*;
#(
    parameter  int BW_COMMAND = 3,
    parameter  int BW_ADDR    = 24,
    parameter  int BW_WORD    = 32,
    parameter  int N_WORDS    = 4,
    localparam int BW_DATA    = BW_WORD * N_WORDS
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    input  logic                  empty_i,
    input  logic [BW_COMMAND-1:0] command_i,
    input  logic [BW_ADDR-1:0]    addr_i,
    input  logic [BW_DATA-1:0]    data_i,
    output logic                  read_o,
    output logic                  mem_req_o,
    output logic                  mem_wren_o,
    output logic [BW_ADDR-1:0]    mem_addr_o,
    output logic [BW_WORD-1:0]    mem_data_o,
    input  logic                  mem_ack_i,
    input  logic [BW_WORD-1:0]    mem_data_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [BW_COMMAND-1:0] resp_command_o,
    output logic [BW_ADDR-1:0]    resp_addr_o,
    output logic [BW_DATA-1:0]    resp_data_o,
    output logic                  busy_o
);

    localparam int          KW     = `CLOG2(N_WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(N_WORDS - 1);

    state_t                state_q;
    state_t                next_state;
    logic [BW_COMMAND-1:0] cmd_q;
    logic [BW_ADDR-1:0]    addr_q;
    logic [BW_DATA-1:0]    data_q;
    logic [BW_DATA-1:0]    line_q;
    logic [KW-1:0]         k_q;

    logic is_block;
    logic is_write;
    logic last_word;
    logic pop;

    assign is_block  = cmd_q[CMD_BLOCK_BIT];
    assign is_write  = cmd_q[CMD_WRITE_BIT];
    // Word ops always run with k = 0, so they finish on their first ack.
    assign last_word = !is_block || (k_q == K_LAST);

    // The pop strobe is gated by reset so it reads 0 while reset is held,
    // even when the buffer is not empty.
    assign pop = (state_q == ST_IDLE) && !empty_i && resetn_i;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    always_comb begin
        next_state   = state_q;
        read_o       = pop;
        mem_req_o    = 1'b0;
        mem_wren_o   = 1'b0;
        resp_valid_o = 1'b0;
        busy_o       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (pop) next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                mem_req_o  = 1'b1;
                mem_wren_o = is_write;
                if (mem_ack_i && last_word) next_state = is_write ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Block accesses walk the aligned line: the low KW address bits are
    // replaced by the word counter.
    assign mem_addr_o = is_block ? {addr_q[BW_ADDR-1:KW], k_q} : addr_q;

    always_comb begin
        mem_data_o = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (k_q == KW'(i)) mem_data_o = data_q[i*BW_WORD +: BW_WORD];
        end
    end

    // Latch the head entry on pop and clear the read line so a word read
    // returns zeros above its low word. Read data lands in slot k.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cmd_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            line_q <= '0;
            k_q    <= '0;
        end else if (pop) begin
            cmd_q  <= command_i;
            addr_q <= addr_i;
            data_q <= data_i;
            line_q <= '0;
            k_q    <= '0;
        end else if ((state_q == ST_ISSUE) && mem_ack_i) begin
            if (!is_write) begin
                for (int i = 0; i < N_WORDS; i++) begin
                    if (k_q == KW'(i)) line_q[i*BW_WORD +: BW_WORD] <= mem_data_i;
                end
            end
            if (!last_word) k_q <= k_q + 1'b1;
        end
    end

    assign resp_command_o = cmd_q;
    assign resp_addr_o    = addr_q;
    assign resp_data_o    = line_q;

endmodule
